// File: rtl/image_write_ctrl_if.sv
// Signal bundle between the image load sequencer and its host / image_write peers.
// The master side drives config, requests and write strobes. The slave side is the controller.
interface image_write_ctrl_if #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CNT_WIDTH  = 24
);
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;
  logic                  start_val;
  logic                  start_rdy;
  logic                  abort;
  logic                  next;
  logic                  wr_val;
  logic                  str_en;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CNT_WIDTH-1:0]  words;

  modport master (
    output cfg_data, cfg_addr, cfg_valid, start_val, abort, wr_val,
    input  start_rdy, next, str_en, busy, done, err, words
  );

  modport slave (
    input  cfg_data, cfg_addr, cfg_valid, start_val, abort, wr_val,
    output start_rdy, next, str_en, busy, done, err, words
  );
endinterface

// File: rtl/image_write_ctrl.sv
// Image load sequencer: it snoops the load length from the config bus and arms image_write.
// It gates the image stream for one load and counts the committed words until completion.
module image_write_ctrl #(
  parameter int                    CFG_DWIDTH   = 32,
  parameter int                    CFG_AWIDTH   = 5,
  parameter logic [CFG_AWIDTH-1:0] CFG_LEN_ADDR = 5'd20,
  parameter int                    CNT_WIDTH    = 24
) (
  input logic               clk,
  input logic               rst_n,
  image_write_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [CNT_WIDTH-1:0] r_len_sh;
  logic [CNT_WIDTH-1:0] r_len_act;
  logic [CNT_WIDTH-1:0] r_words;
  logic                 r_next;
  logic                 r_str_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 w_cfg_len_hit;
  logic                 w_accept;
  logic                 w_inc;
  logic                 w_last;
  logic                 w_spurious;
  logic                 w_underrun;

  assign w_cfg_len_hit = bus.cfg_valid && (bus.cfg_addr == CFG_LEN_ADDR);
  assign w_accept      = (r_state == S_IDLE) && bus.start_val;
  assign w_inc         = (r_state == S_RUN) && bus.wr_val;
  // Compare before the increment, so an all-ones length never has to represent len+1.
  assign w_last        = w_inc && (r_words == r_len_act);
  assign w_spurious    = bus.wr_val && (r_state != S_RUN);
  assign w_underrun    = bus.abort && (r_state == S_RUN) && (r_words <= r_len_act);

  // NOTE: every combinational output gets a default first so that no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_val) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a coincident final word.
    if (bus.abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Outputs are decoded from the next state, so they are registered and aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next   <= 1'b0;
      r_str_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_next   <= (w_state_nxt == S_ARM);
      r_str_en <= (w_state_nxt == S_RUN);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_sh  <= '0;
      r_len_act <= '0;
      r_words   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_cfg_len_hit) r_len_sh <= bus.cfg_data[CNT_WIDTH-1:0];
      // A cfg write in the accept cycle only lands in the shadow, so the old length is used.
      if (w_accept) begin
        r_len_act <= r_len_sh;
        r_words   <= '0;
      end else if (w_inc) begin
        r_words <= r_words + CNT_WIDTH'(1);
      end
      if (w_spurious || w_underrun) r_err <= 1'b1;
      else if (w_accept)            r_err <= 1'b0;
    end
  end

  if (CNT_WIDTH < CFG_DWIDTH) begin : g_cfg_hi
    logic w_unused_cfg_hi;
    assign w_unused_cfg_hi = |bus.cfg_data[CFG_DWIDTH-1:CNT_WIDTH];
  end

  assign bus.start_rdy = (r_state == S_IDLE);
  assign bus.next      = r_next;
  assign bus.str_en    = r_str_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.words     = r_words;

endmodule

// File: tb/tb_image_write_ctrl.sv
// Directed bench for image_write_ctrl: a table of whole-load scenarios plus cycle-exact
// sequences for the handshake timing, the same-cycle cfg write and the asynchronous reset.
`timescale 1ns/1ps
module tb_image_write_ctrl;
  localparam int         CFG_DWIDTH = 32;
  localparam int         CFG_AWIDTH = 5;
  localparam int         CNT_WIDTH  = 24;
  localparam logic [4:0] LEN_ADDR   = 5'd20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_next   = 0;
  int n_str    = 0;

  image_write_ctrl_if #(.CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .CNT_WIDTH(CNT_WIDTH)) u_if ();

  image_write_ctrl #(
    .CFG_DWIDTH  (CFG_DWIDTH),
    .CFG_AWIDTH  (CFG_AWIDTH),
    .CFG_LEN_ADDR(LEN_ADDR),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (u_if.done)   n_done++;
    if (u_if.next)   n_next++;
    if (u_if.str_en) n_str++;
  end

  typedef struct {
    logic [23:0] len;
    int          gap;
    int          n_wr;
    int          abort_mode;  // 0 none, 1 abort alone after the beats, 2 abort with the last beat
    logic [23:0] exp_words;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_len(input logic [23:0] len);
    u_if.cfg_addr  = LEN_ADDR;
    u_if.cfg_data  = {8'hA5, len};
    u_if.cfg_valid = 1'b1;
    tick();
    u_if.cfg_valid = 1'b0;
  endtask

  task automatic start();
    u_if.start_val = 1'b1;
    tick();
    u_if.start_val = 1'b0;
  endtask

  task automatic beat();
    u_if.wr_val = 1'b1;
    tick();
    u_if.wr_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done;
    int base_next;
    int base_str;

    //              len  gap n_wr abort words done err
    vecs[0] = '{24'd7,  0, 8, 0, 24'd8, 1'b1, 1'b0};
    vecs[1] = '{24'd0,  3, 1, 0, 24'd1, 1'b1, 1'b0};
    vecs[2] = '{24'd15, 0, 5, 1, 24'd5, 1'b0, 1'b1};
    vecs[3] = '{24'd3,  2, 4, 0, 24'd4, 1'b1, 1'b0};
    vecs[4] = '{24'd2,  0, 3, 2, 24'd3, 1'b0, 1'b1};
    vecs[5] = '{24'd4,  1, 2, 1, 24'd2, 1'b0, 1'b1};
    vecs[6] = '{24'd1,  0, 2, 0, 24'd2, 1'b1, 1'b0};

    u_if.cfg_data  = '0;
    u_if.cfg_addr  = '0;
    u_if.cfg_valid = 1'b0;
    u_if.start_val = 1'b0;
    u_if.abort     = 1'b0;
    u_if.wr_val    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst next",   u_if.next,   0);
    check("rst str_en", u_if.str_en, 0);
    check("rst busy",   u_if.busy,   0);
    check("rst done",   u_if.done,   0);
    check("rst err",    u_if.err,    0);
    check("rst words",  u_if.words,  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst start_rdy", u_if.start_rdy, 1);

    // Table-driven whole-load scenarios
    for (int i = 0; i < 7; i++) begin
      cfg_len(vecs[i].len);
      base_done = n_done;
      start();
      tick();
      for (int b = 0; b < vecs[i].n_wr; b++) begin
        repeat (vecs[i].gap) tick();
        u_if.wr_val = 1'b1;
        if (vecs[i].abort_mode == 2 && b == vecs[i].n_wr - 1) u_if.abort = 1'b1;
        tick();
        u_if.wr_val = 1'b0;
        u_if.abort  = 1'b0;
      end
      if (vecs[i].abort_mode == 1) begin
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
      end
      check($sformatf("v%0d words", i),  u_if.words,  {8'h0, vecs[i].exp_words});
      check($sformatf("v%0d err", i),    u_if.err,    {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d done", i),   u_if.done,   {31'h0, vecs[i].exp_done});
      check($sformatf("v%0d str_en", i), u_if.str_en, 0);
      if (vecs[i].exp_done) tick();
      check($sformatf("v%0d start_rdy", i), u_if.start_rdy, 1);
      check($sformatf("v%0d busy", i),      u_if.busy,      0);
      check($sformatf("v%0d done_cnt", i),  n_done - base_done, {31'h0, vecs[i].exp_done});
    end

    // Cycle-exact handshake timing, len=7 with continuous beats
    cfg_len(24'd7);
    base_next = n_next;
    u_if.start_val = 1'b1;
    check("A start_rdy idle", u_if.start_rdy, 1);
    tick();
    u_if.start_val = 1'b0;
    check("A T+1 next",      u_if.next,      1);
    check("A T+1 busy",      u_if.busy,      1);
    check("A T+1 str_en",    u_if.str_en,    0);
    check("A T+1 start_rdy", u_if.start_rdy, 0);
    tick();
    check("A T+2 next",   u_if.next,   0);
    check("A T+2 str_en", u_if.str_en, 1);
    base_str = n_str;
    u_if.wr_val = 1'b1;
    repeat (8) tick();
    u_if.wr_val = 1'b0;
    check("A F+1 done",      u_if.done,      1);
    check("A F+1 str_en",    u_if.str_en,    0);
    check("A F+1 words",     u_if.words,     8);
    check("A F+1 start_rdy", u_if.start_rdy, 0);
    check("A F+1 err",       u_if.err,       0);
    tick();
    check("A F+2 start_rdy", u_if.start_rdy, 1);
    check("A F+2 done",      u_if.done,      0);
    check("A F+2 busy",      u_if.busy,      0);
    check("A next pulses",   n_next - base_next, 1);
    check("A str_en cycles", n_str - base_str,   8);

    // A cfg write in the accept cycle only affects the following load
    cfg_len(24'd1);
    u_if.cfg_addr  = LEN_ADDR;
    u_if.cfg_data  = 32'h0000_0003;
    u_if.cfg_valid = 1'b1;
    u_if.start_val = 1'b1;
    tick();
    u_if.cfg_valid = 1'b0;
    u_if.start_val = 1'b0;
    tick();
    beat();
    check("B1 done after 1", u_if.done, 0);
    beat();
    check("B1 done after 2",  u_if.done,  1);
    check("B1 words",         u_if.words, 2);
    tick();
    start();
    tick();
    repeat (3) beat();
    check("B2 done after 3", u_if.done, 0);
    beat();
    check("B2 done after 4", u_if.done,  1);
    check("B2 words",        u_if.words, 4);
    tick();

    // Spurious write in IDLE
    check("C err before", u_if.err, 0);
    beat();
    check("C err",       u_if.err,       1);
    check("C start_rdy", u_if.start_rdy, 1);
    check("C busy",      u_if.busy,      0);
    check("C words",     u_if.words,     4);
    tick();
    check("C start_rdy hold", u_if.start_rdy, 1);

    // Spurious write in ARM, then asynchronous reset mid-RUN
    cfg_len(24'd7);
    start();
    check("D start clears err", u_if.err, 0);
    beat();
    check("D arm wr err", u_if.err,   1);
    check("D arm words",  u_if.words, 0);
    beat();
    beat();
    check("D words mid-run", u_if.words,  2);
    check("D str_en on",     u_if.str_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("D async str_en",    u_if.str_en,    0);
    check("D async busy",      u_if.busy,      0);
    check("D async next",      u_if.next,      0);
    check("D async done",      u_if.done,      0);
    check("D async err",       u_if.err,       0);
    check("D async words",     u_if.words,     0);
    check("D async start_rdy", u_if.start_rdy, 1);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // The shadow length resets to 0, so a start without cfg is a one-word load.
    start();
    tick();
    beat();
    check("D len_sh rst done",  u_if.done,  1);
    check("D len_sh rst words", u_if.words, 1);
    tick();
    cfg_len(24'd3);
    start();
    tick();
    repeat (4) beat();
    check("D post-rst done",  u_if.done,  1);
    check("D post-rst words", u_if.words, 4);
    check("D post-rst err",   u_if.err,   0);
    tick();
    check("D post-rst idle", u_if.start_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
